conv_seq_ctrl: RTL and testbench

Parametrised sequencer for the conv engine. It generates the read strobes and the kernel/channel/row/column indices that drive weight and feature-map fetch, plus accumulate-control flags, for any KxK kernel over an FMAP_H x FMAP_W map. It sits between the top-level start/config interface and the memory fetch and MAC datapath. It generalises the fixed 4x4/64x64/34-cycle schedule, and adds a hold (stall) input, a done pulse and per-job config latching.

---
 rtl/conv_pkg.sv | 29 ++
 rtl/wrap_counter.sv | 27 ++
 rtl/conv_seq_ctrl.sv | 129 ++++++++++++
 tb/tb_conv_seq_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the conv engine sequencer: geometry defaults, derived
// schedule lengths, FSM encoding and config decoding helpers.
package conv_pkg;

  localparam int K_DEF      = 4;
  localparam int FMAP_W_DEF = 64;
  localparam int FMAP_H_DEF = 64;
  localparam int MAX_CH_DEF = 32;

  localparam int WCYC_DEF     = K_DEF * K_DEF / 8;
  localparam int CCYC_DEF     = FMAP_W_DEF / 2;
  localparam int OUT_ROWS_DEF = FMAP_H_DEF - K_DEF + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cfg_count(input logic [1:0] cfg);
    return 8 * (int'(cfg) + 1);
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Enable/limit counter that returns to zero after reaching its limit; the
// wrap flag is the carry that enables the next counter in a chain.
module wrap_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  assign wrap = en && (cnt == limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/conv_seq_ctrl.sv
// Conv engine sequencer: walks phase -> channel -> row -> kernel for one job
// and emits weight/fmap fetch strobes, indices and accumulate flags.
module conv_seq_ctrl
  import conv_pkg::*;
#(
  parameter int K      = K_DEF,
  parameter int FMAP_W = FMAP_W_DEF,
  parameter int FMAP_H = FMAP_H_DEF,
  parameter int MAX_CH = MAX_CH_DEF
) (
  input  logic                           clk,
  input  logic                           in_rst_n,
  input  logic                           in_start_conv,
  input  logic [2:0]                     in_cfg_ci,
  input  logic [2:0]                     in_cfg_co,
  input  logic                           in_hold,
  output logic                           out_readw_ctl,
  output logic                           out_readi_ctl,
  output logic [idx_w(MAX_CH)-1:0]       out_knl_idx,
  output logic [idx_w(MAX_CH)-1:0]       out_ch_idx,
  output logic [idx_w(FMAP_H)-1:0]       out_row_idx,
  output logic [idx_w(FMAP_W/2)-1:0]     out_col_idx,
  output logic [idx_w(K*K/8)-1:0]        out_wpart_idx,
  output logic                           out_acc_first,
  output logic                           out_acc_last,
  output logic                           out_busy,
  output logic                           out_end_conv
);

  localparam int WCYC = K * K / 8;
  localparam int CCYC = FMAP_W / 2;
  localparam int PH   = CCYC + WCYC;
  localparam int PW   = idx_w(PH);
  localparam int CHW  = idx_w(MAX_CH);
  localparam int RW   = idx_w(FMAP_H);
  localparam int CW   = idx_w(CCYC);
  localparam int WPW  = idx_w(WCYC);

  localparam logic [PW-1:0] C_LIM   = PW'(PH - 1);
  localparam logic [PW-1:0] WCYC_C  = PW'(WCYC);
  localparam logic [PW-1:0] CCYC_C  = PW'(CCYC);
  localparam logic [RW-1:0] ROW_LIM = RW'(FMAP_H - K);

  logic [1:0]     rst_sync;
  logic           rst_n;
  state_t         state;
  logic [1:0]     ci_q, co_q;
  logic [CHW-1:0] nch_lim, nko_lim;
  logic [PW-1:0]  c;
  logic [CHW-1:0] ch, knl;
  logic [RW-1:0]  row;
  logic           c_wrap, ch_wrap, row_wrap, knl_wrap;
  logic           run, adv, clr;
  logic           unused_cfg;

  // Reset asserts asynchronously but is released on a clock edge.
  always_ff @(posedge clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      rst_sync <= '0;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end
  assign rst_n = rst_sync[1];

  assign unused_cfg = in_cfg_ci[2] ^ in_cfg_co[2];
  assign nch_lim    = CHW'(cfg_count(ci_q) - 1);
  assign nko_lim    = CHW'(cfg_count(co_q) - 1);

  assign run = (state == ST_RUN);
  assign adv = run && !in_hold;
  assign clr = !run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ci_q  <= '0;
      co_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_start_conv) begin
            state <= ST_RUN;
            ci_q  <= in_cfg_ci[1:0];
            co_q  <= in_cfg_co[1:0];
          end
        end
        ST_RUN:  if (knl_wrap) state <= ST_DONE;
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Counter chain: each stage advances on the wrap of the one below it.
  wrap_counter #(.W(PW)) u_phase (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(adv),
    .limit(C_LIM), .cnt(c), .wrap(c_wrap)
  );

  wrap_counter #(.W(CHW)) u_ch (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(c_wrap),
    .limit(nch_lim), .cnt(ch), .wrap(ch_wrap)
  );

  wrap_counter #(.W(RW)) u_row (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(ch_wrap),
    .limit(ROW_LIM), .cnt(row), .wrap(row_wrap)
  );

  wrap_counter #(.W(CHW)) u_knl (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(row_wrap),
    .limit(nko_lim), .cnt(knl), .wrap(knl_wrap)
  );

  // Strobes drop during hold while indices stay put, so no fetch repeats.
  assign out_readw_ctl = adv && (c < WCYC_C);
  assign out_readi_ctl = adv && (c < CCYC_C);
  assign out_wpart_idx = c[WPW-1:0];
  assign out_col_idx   = c[CW-1:0];
  assign out_ch_idx    = ch;
  assign out_row_idx   = row;
  assign out_knl_idx   = knl;
  assign out_acc_first = run && (ch == '0);
  assign out_acc_last  = run && (ch == nch_lim);
  assign out_busy      = (state != ST_IDLE);
  assign out_end_conv  = (state == ST_DONE);

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Bench for conv_seq_ctrl on a small geometry (K=4, 8x6 map) with an
// arithmetic progress model checked every cycle.
module tb_conv_seq_ctrl;

  localparam int WC   = 2;
  localparam int CC   = 4;
  localparam int PH   = 6;
  localparam int ROWS = 3;

  logic       clk = 1'b0;
  logic       in_rst_n = 1'b1;
  logic       in_start_conv = 1'b0;
  logic       in_hold = 1'b0;
  logic [2:0] in_cfg_ci = 3'd0;
  logic [2:0] in_cfg_co = 3'd0;
  logic       out_readw_ctl, out_readi_ctl;
  logic [4:0] out_knl_idx, out_ch_idx;
  logic [2:0] out_row_idx;
  logic [1:0] out_col_idx;
  logic [0:0] out_wpart_idx;
  logic       out_acc_first, out_acc_last, out_busy, out_end_conv;

  int n_cmp = 0;
  int n_bad = 0;
  int n_end = 0;

  always #5 clk = ~clk;

  conv_seq_ctrl #(.K(4), .FMAP_W(8), .FMAP_H(6), .MAX_CH(32)) dut (
    .clk(clk), .in_rst_n(in_rst_n), .in_start_conv(in_start_conv),
    .in_cfg_ci(in_cfg_ci), .in_cfg_co(in_cfg_co), .in_hold(in_hold),
    .out_readw_ctl(out_readw_ctl), .out_readi_ctl(out_readi_ctl),
    .out_knl_idx(out_knl_idx), .out_ch_idx(out_ch_idx),
    .out_row_idx(out_row_idx), .out_col_idx(out_col_idx),
    .out_wpart_idx(out_wpart_idx), .out_acc_first(out_acc_first),
    .out_acc_last(out_acc_last), .out_busy(out_busy),
    .out_end_conv(out_end_conv)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: a job is just a count t of advancing cycles; indices are digits of t.
  int  m_st = 0;
  int  m_t = 0;
  int  m_nch = 8;
  int  m_nko = 8;
  int  m_sync = 0;
  bit  chk_on = 1'b0;

  always @(posedge clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      m_st = 0; m_t = 0; m_sync = 0;
    end else begin
      if (m_sync >= 2) begin
        if (m_st == 0) begin
          if (in_start_conv) begin
            m_st  = 1;
            m_t   = 0;
            m_nch = 8 * (int'(in_cfg_ci[1:0]) + 1);
            m_nko = 8 * (int'(in_cfg_co[1:0]) + 1);
          end
        end else if (m_st == 1) begin
          if (!in_hold) begin
            m_t++;
            if (m_t == m_nko * ROWS * m_nch * PH) m_st = 2;
          end
        end else begin
          m_st = 0;
        end
      end
      if (m_sync < 2) m_sync++;
    end
  end

  int e_c, e_ch, e_row, e_knl;
  bit e_run, e_act;

  always @(negedge clk) begin
    if (chk_on) begin
      e_run = (m_st == 1);
      e_act = e_run && !in_hold;
      e_c   = m_t % PH;
      e_ch  = e_run ? (m_t / PH) % m_nch : 0;
      e_row = e_run ? (m_t / (PH * m_nch)) % ROWS : 0;
      e_knl = e_run ? m_t / (PH * m_nch * ROWS) : 0;
      chk("readw",     int'(out_readw_ctl), int'(e_act && e_c < WC));
      chk("readi",     int'(out_readi_ctl), int'(e_act && e_c < CC));
      chk("knl",       int'(out_knl_idx), e_knl);
      chk("ch",        int'(out_ch_idx), e_ch);
      chk("row",       int'(out_row_idx), e_row);
      chk("acc_first", int'(out_acc_first), int'(e_run && e_ch == 0));
      chk("acc_last",  int'(out_acc_last), int'(e_run && e_ch == m_nch - 1));
      chk("busy",      int'(out_busy), int'(m_st != 0));
      chk("end_conv",  int'(out_end_conv), int'(m_st == 2));
      if (e_run && e_c < CC) chk("col", int'(out_col_idx), e_c);
      if (e_run && e_c < WC) chk("wpart", int'(out_wpart_idx), e_c);
      if (out_end_conv) n_end++;
    end
  end

  task automatic run_job(input string nm, input logic [2:0] ci, input logic [2:0] co,
                         input int exp_len, input int nko, input int nch,
                         input bit hold_rand, input bit poke);
    int k, nh, maxk;
    bit done;
    in_cfg_ci = ci; in_cfg_co = co; in_start_conv = 1'b1;
    @(posedge clk); #1;
    in_start_conv = 1'b0;
    k = 0; nh = 0; maxk = 0; done = 1'b0;
    while (!done && k < 2 * exp_len + 100) begin
      in_hold = hold_rand && (k > PH * nch) && ($urandom_range(0, 7) == 0);
      if (poke && k == 500) begin
        in_cfg_ci = 3'd0; in_cfg_co = 3'd0; in_start_conv = 1'b1;
      end
      if (poke && k == 501) in_start_conv = 1'b0;
      @(negedge clk);
      if (out_end_conv) begin
        done = 1'b1;
      end else begin
        if (in_hold) nh++;
        if (out_readi_ctl && int'(out_knl_idx) > maxk) maxk = int'(out_knl_idx);
        if (k == 0) begin
          chk({nm, "_first_knl"}, int'(out_knl_idx), 0);
          chk({nm, "_first_readw"}, int'(out_readw_ctl), 1);
        end
        if (k == 6) chk({nm, "_k6_ch"}, int'(out_ch_idx), 1);
        if (k == PH * nch) begin
          chk({nm, "_row1_row"}, int'(out_row_idx), 1);
          chk({nm, "_row1_first"}, int'(out_acc_first), 1);
        end
        k++;
      end
      @(posedge clk); #1;
    end
    in_hold = 1'b0;
    chk({nm, "_ended"}, int'(done), 1);
    chk({nm, "_len"}, k - nh, exp_len);
    chk({nm, "_maxknl"}, maxk, nko - 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
    $fatal(1);
  end

  initial begin
    int ri, rw, ends0;
    // Reset held with start asserted: nothing may move.
    #3 in_rst_n = 1'b0;
    chk_on = 1'b1;
    in_start_conv = 1'b1; in_cfg_ci = 3'd3; in_cfg_co = 3'd3;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_busy", int'(out_busy), 0);
    chk("rst_readi", int'(out_readi_ctl), 0);
    chk("rst_end", int'(out_end_conv), 0);
    in_start_conv = 1'b0;
    in_rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Job A: cfg 0/0, no hold, exact latency and strobe totals.
    in_cfg_ci = 3'd0; in_cfg_co = 3'd0; in_start_conv = 1'b1;
    @(posedge clk); #1;
    in_start_conv = 1'b0;
    ri = 0; rw = 0;
    for (int k = 0; k < 1152; k++) begin
      @(negedge clk);
      ri += int'(out_readi_ctl);
      rw += int'(out_readw_ctl);
      if (k < 6) begin
        chk("A_pat_readw", int'(out_readw_ctl), int'(k < 2));
        chk("A_pat_readi", int'(out_readi_ctl), int'(k < 4));
      end
      if (k == 6) begin
        chk("A_k6_ch", int'(out_ch_idx), 1);
        chk("A_k6_wpart", int'(out_wpart_idx), 0);
      end
      if (k == 48) begin
        chk("A_k48_row", int'(out_row_idx), 1);
        chk("A_k48_ch", int'(out_ch_idx), 0);
        chk("A_k48_first", int'(out_acc_first), 1);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("A_end_at_1152", int'(out_end_conv), 1);
    chk("A_readi_total", ri, 768);
    chk("A_readw_total", rw, 384);
    @(posedge clk); #1;

    // Job B: 5-cycle hold at c=1 of ch 3 (run cycle 19).
    in_start_conv = 1'b1;
    @(posedge clk); #1;
    in_start_conv = 1'b0;
    rw = 0;
    for (int k = 0; k < 1157; k++) begin
      in_hold = (k >= 19 && k < 24);
      @(negedge clk);
      rw += int'(out_readw_ctl);
      if (k >= 19 && k < 24) begin
        chk("B_hold_readw", int'(out_readw_ctl), 0);
        chk("B_hold_readi", int'(out_readi_ctl), 0);
        chk("B_hold_wpart", int'(out_wpart_idx), 1);
        chk("B_hold_col", int'(out_col_idx), 1);
        chk("B_hold_ch", int'(out_ch_idx), 3);
      end
      if (k == 24) begin
        chk("B_resume_readw", int'(out_readw_ctl), 1);
        chk("B_resume_wpart", int'(out_wpart_idx), 1);
      end
      @(posedge clk); #1;
    end
    in_hold = 1'b0;
    @(negedge clk);
    chk("B_end_at_1157", int'(out_end_conv), 1);
    chk("B_readw_total", rw, 384);
    @(posedge clk); #1;

    // Job C: cfg 3/3 with random holds and an ignored restart; then D on new cfg.
    run_job("C", 3'd3, 3'd3, 18432, 32, 32, 1'b1, 1'b1);
    run_job("D", in_cfg_ci, in_cfg_co, 1152, 8, 8, 1'b1, 1'b0);

    // Job E: reset mid-row aborts with no end pulse.
    ends0 = n_end;
    in_cfg_ci = 3'd1; in_cfg_co = 3'd1; in_start_conv = 1'b1;
    @(posedge clk); #1;
    in_start_conv = 1'b0;
    repeat (300) @(posedge clk);
    #3 in_rst_n = 1'b0;
    #1;
    chk("E_rst_busy", int'(out_busy), 0);
    chk("E_rst_readi", int'(out_readi_ctl), 0);
    chk("E_rst_readw", int'(out_readw_ctl), 0);
    chk("E_rst_ch", int'(out_ch_idx), 0);
    chk("E_rst_row", int'(out_row_idx), 0);
    repeat (2) @(posedge clk);
    #1 in_rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("E_no_end", n_end, ends0);
    run_job("F", 3'd0, 3'd0, 1152, 8, 8, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
